// File: rtl/mem_alu_pipe.sv
// Dual-bank operand memory feeding a two-stage ALU pipeline with valid/ready on command and result.
// Optional build macro ALU_SAT_EN: ADD/INC saturate to all-ones and SUB/DEC saturate to zero.
module mem_alu_pipe #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  wr_en_a,
    input  logic [ADDR_WIDTH-1:0] wr_addr_a,
    input  logic [DATA_WIDTH-1:0] wr_data_a,
    input  logic                  wr_en_b,
    input  logic [ADDR_WIDTH-1:0] wr_addr_b,
    input  logic [DATA_WIDTH-1:0] wr_data_b,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [3:0]            cmd_opcode,
    input  logic [ADDR_WIDTH-1:0] cmd_addr_a,
    input  logic [ADDR_WIDTH-1:0] cmd_addr_b,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [DATA_WIDTH-1:0] res_data,
    output logic                  res_carry,
    output logic                  res_zero,
    output logic                  res_illegal
);

    localparam int W     = DATA_WIDTH;
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    localparam logic [3:0] OP_ADD    = 4'd0;
    localparam logic [3:0] OP_SUB    = 4'd1;
    localparam logic [3:0] OP_AND    = 4'd2;
    localparam logic [3:0] OP_OR     = 4'd3;
    localparam logic [3:0] OP_XOR    = 4'd4;
    localparam logic [3:0] OP_NOT    = 4'd5;
    localparam logic [3:0] OP_SHL    = 4'd6;
    localparam logic [3:0] OP_SHR    = 4'd7;
    localparam logic [3:0] OP_PASS_A = 4'd8;
    localparam logic [3:0] OP_PASS_B = 4'd9;
    localparam logic [3:0] OP_INC    = 4'd10;
    localparam logic [3:0] OP_DEC    = 4'd11;

    // Handshake: a transfer happens on any rising edge where valid && ready.
    // The producer holds its payload stable while valid is high and ready is low.
    logic [W-1:0] mem_a_q [DEPTH];
    logic [W-1:0] mem_b_q [DEPTH];

    logic         s1_valid_q, s1_valid_d;
    logic [3:0]   s1_op_q, s1_op_d;
    logic [W-1:0] s1_a_q, s1_a_d;
    logic [W-1:0] s1_b_q, s1_b_d;

    logic         res_valid_q, res_valid_d;
    logic [W-1:0] res_data_q, res_data_d;
    logic         res_carry_q, res_carry_d;
    logic         res_zero_q, res_zero_d;
    logic         res_illegal_q, res_illegal_d;

    logic         advance;
    logic         accept;
    logic [W-1:0] rd_a, rd_b;
    logic [W:0]   wide;
    logic [W-1:0] alu_data;
    logic         alu_carry, alu_zero, alu_illegal;

    // Banks have no reset so that contents survive a pipeline reset.
    always_ff @(posedge clk) begin
        if (wr_en_a) mem_a_q[wr_addr_a] <= wr_data_a;
        if (wr_en_b) mem_b_q[wr_addr_b] <= wr_data_b;
    end

    assign advance   = !res_valid_q || res_ready;
    assign cmd_ready = reset_n && (!s1_valid_q || advance);
    assign accept    = cmd_valid && cmd_ready;

    always_comb begin
        rd_a = (wr_en_a && (wr_addr_a == cmd_addr_a)) ? wr_data_a : mem_a_q[cmd_addr_a];
        rd_b = (wr_en_b && (wr_addr_b == cmd_addr_b)) ? wr_data_b : mem_b_q[cmd_addr_b];
    end

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_op_d    = s1_op_q;
        s1_a_d     = s1_a_q;
        s1_b_d     = s1_b_q;
        if (accept) begin
            s1_valid_d = 1'b1;
            s1_op_d    = cmd_opcode;
            s1_a_d     = rd_a;
            s1_b_d     = rd_b;
        end else if (advance) begin
            s1_valid_d = 1'b0;
        end
    end

    always_comb begin
        wide        = '0;
        alu_data    = '0;
        alu_carry   = 1'b0;
        alu_illegal = 1'b0;
        case (s1_op_q)
            OP_ADD: begin
                wide      = {1'b0, s1_a_q} + {1'b0, s1_b_q};
                alu_data  = wide[W-1:0];
                alu_carry = wide[W];
            end
            OP_SUB: begin
                wide      = {1'b0, s1_a_q} - {1'b0, s1_b_q};
                alu_data  = wide[W-1:0];
                alu_carry = wide[W];
            end
            OP_AND:    alu_data = s1_a_q & s1_b_q;
            OP_OR:     alu_data = s1_a_q | s1_b_q;
            OP_XOR:    alu_data = s1_a_q ^ s1_b_q;
            OP_NOT:    alu_data = ~s1_a_q;
            OP_SHL: begin
                alu_data  = {s1_a_q[W-2:0], 1'b0};
                alu_carry = s1_a_q[W-1];
            end
            OP_SHR: begin
                alu_data  = {1'b0, s1_a_q[W-1:1]};
                alu_carry = s1_a_q[0];
            end
            OP_PASS_A: alu_data = s1_a_q;
            OP_PASS_B: alu_data = s1_b_q;
            OP_INC: begin
                wide      = {1'b0, s1_a_q} + (W+1)'(1);
                alu_data  = wide[W-1:0];
                alu_carry = wide[W];
            end
            OP_DEC: begin
                wide      = {1'b0, s1_a_q} - (W+1)'(1);
                alu_data  = wide[W-1:0];
                alu_carry = wide[W];
            end
            default:   alu_illegal = 1'b1;
        endcase
`ifdef ALU_SAT_EN
        if (alu_carry) begin
            case (s1_op_q)
                OP_ADD, OP_INC: alu_data = '1;
                OP_SUB, OP_DEC: alu_data = '0;
                default:        alu_data = alu_data;
            endcase
        end
`endif
        alu_zero = (alu_data == '0);
    end

    // S2 only moves on advance, which is what holds res_* stable under backpressure.
    always_comb begin
        res_valid_d   = res_valid_q;
        res_data_d    = res_data_q;
        res_carry_d   = res_carry_q;
        res_zero_d    = res_zero_q;
        res_illegal_d = res_illegal_q;
        if (advance) begin
            res_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                res_data_d    = alu_data;
                res_carry_d   = alu_carry;
                res_zero_d    = alu_zero;
                res_illegal_d = alu_illegal;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid_q    <= 1'b0;
            s1_op_q       <= '0;
            s1_a_q        <= '0;
            s1_b_q        <= '0;
            res_valid_q   <= 1'b0;
            res_data_q    <= '0;
            res_carry_q   <= 1'b0;
            res_zero_q    <= 1'b0;
            res_illegal_q <= 1'b0;
        end else begin
            s1_valid_q    <= s1_valid_d;
            s1_op_q       <= s1_op_d;
            s1_a_q        <= s1_a_d;
            s1_b_q        <= s1_b_d;
            res_valid_q   <= res_valid_d;
            res_data_q    <= res_data_d;
            res_carry_q   <= res_carry_d;
            res_zero_q    <= res_zero_d;
            res_illegal_q <= res_illegal_d;
        end
    end

    assign res_valid   = res_valid_q;
    assign res_data    = res_data_q;
    assign res_carry   = res_carry_q;
    assign res_zero    = res_zero_q;
    assign res_illegal = res_illegal_q;

endmodule
